// File: rtl/present_ti_round_ctrl.sv
// present_ti_round_ctrl: serial 3-share PRESENT datapath around an external TI S-box.
// Define PRESENT_TI_KEYADD_MERGE_EN to fold the round key add into the S-box pass.
module present_ti_round_ctrl #(
  parameter int NROUNDS  = 31,
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pt1,
  input  logic [63:0] pt2,
  input  logic [63:0] pt3,
  input  logic [63:0] rk1,
  input  logic [63:0] rk2,
  input  logic [63:0] rk3,
  output logic [4:0]  round_idx,
  output logic [3:0]  sboxIn1,
  output logic [3:0]  sboxIn2,
  output logic [3:0]  sboxIn3,
  input  logic [3:0]  share1,
  input  logic [3:0]  share2,
  input  logic [3:0]  share3,
  output logic [63:0] ct1,
  output logic [63:0] ct2,
  output logic [63:0] ct3,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, KEYADD, SBOX, PLAYER, FINAL, DONE
  } state_t;

`ifdef PRESENT_TI_KEYADD_MERGE_EN
  localparam state_t ENTRY = SBOX;
  localparam logic   MERGE = 1'b1;
`else
  localparam state_t ENTRY = KEYADD;
  localparam logic   MERGE = 1'b0;
`endif

  localparam logic [4:0] LAST = 5'(15 + SBOX_LAT);
  localparam logic [4:0] NR   = 5'(NROUNDS);

  state_t      st, st_nx;
  logic [63:0] s1, s2, s3;
  logic [63:0] s1_nx, s2_nx, s3_nx;
  logic [4:0]  ri_nx, nib_cnt, nc_nx;
  logic        busy_nx, done_nx, load;
  logic [3:0]  wb;
  logic [5:0]  rd, wr;

  function automatic logic [63:0] play(input logic [63:0] x);
    logic [63:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
    return y;
  endfunction

  assign ct1 = s1;
  assign ct2 = s2;
  assign ct3 = s3;
  assign rd  = {nib_cnt[3:0], 2'b00};
  assign wb  = nib_cnt[3:0] - 4'd1;
  assign wr  = {wb, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      round_idx <= '0;
      nib_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st        <= st_nx;
      s1        <= s1_nx;
      s2        <= s2_nx;
      s3        <= s3_nx;
      round_idx <= ri_nx;
      nib_cnt   <= nc_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    s1_nx   = s1;
    s2_nx   = s2;
    s3_nx   = s3;
    ri_nx   = round_idx;
    nc_nx   = nib_cnt;
    busy_nx = busy;
    done_nx = 1'b0;
    load    = 1'b0;
    sboxIn1 = 4'd0;
    sboxIn2 = 4'd0;
    sboxIn3 = 4'd0;
    unique case (st)
      IDLE: load = start;
      KEYADD: begin
        s1_nx = s1 ^ rk1;
        s2_nx = s2 ^ rk2;
        s3_nx = s3 ^ rk3;
        nc_nx = 5'd0;
        st_nx = SBOX;
      end
      SBOX: begin
        if (nib_cnt < 5'd16) begin
          sboxIn1 = s1[rd +: 4] ^ (rk1[rd +: 4] & {4{MERGE}});
          sboxIn2 = s2[rd +: 4] ^ (rk2[rd +: 4] & {4{MERGE}});
          sboxIn3 = s3[rd +: 4] ^ (rk3[rd +: 4] & {4{MERGE}});
        end
        // S-box result for nibble c-1 arrives while nibble c is sent
        if (nib_cnt != 5'd0) begin
          s1_nx[wr +: 4] = share1;
          s2_nx[wr +: 4] = share2;
          s3_nx[wr +: 4] = share3;
        end
        if (nib_cnt == LAST) st_nx = PLAYER;
        else nc_nx = nib_cnt + 5'd1;
      end
      PLAYER: begin
        s1_nx = play(s1);
        s2_nx = play(s2);
        s3_nx = play(s3);
        nc_nx = 5'd0;
        if (round_idx < NR) begin
          ri_nx = round_idx + 5'd1;
          st_nx = ENTRY;
        end else begin
          // round key 32 wraps to index 0 on the 5-bit bus
          ri_nx = 5'd0;
          st_nx = FINAL;
        end
      end
      FINAL: begin
        s1_nx   = s1 ^ rk1;
        s2_nx   = s2 ^ rk2;
        s3_nx   = s3 ^ rk3;
        busy_nx = 1'b0;
        done_nx = 1'b1;
        st_nx   = DONE;
      end
      DONE: begin
        load = start;
        if (!start) begin
          ri_nx = 5'd0;
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
    if (load) begin
      s1_nx   = pt1;
      s2_nx   = pt2;
      s3_nx   = pt3;
      ri_nx   = 5'd1;
      nc_nx   = 5'd0;
      busy_nx = 1'b1;
      st_nx   = ENTRY;
    end
  end

endmodule

// File: tb/tb_present_ti_round_ctrl.sv
// tb_present_ti_round_ctrl: directed vectors for the 3-share PRESENT round controller.
// Honors PRESENT_TI_KEYADD_MERGE_EN to match the DUT build.
module tb_present_ti_round_ctrl;

`ifdef PRESENT_TI_KEYADD_MERGE_EN
  localparam int LAT = 560;
  localparam int C0  = 0;
`else
  localparam int LAT = 591;
  localparam int C0  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] pt1, pt2, pt3;
  logic [63:0] rk1, rk2, rk3;
  logic [63:0] ct1, ct2, ct3;
  logic [4:0]  round_idx;
  logic [3:0]  sboxIn1, sboxIn2, sboxIn3;
  logic [3:0]  share1, share2, share3;
  logic [3:0]  m1, m2;
  logic        busy, done;
  logic [63:0] rka [0:31];
  logic [63:0] rkb [0:31];
  logic [63:0] rkc [0:31];
  int          checks = 0;
  int          errors = 0;
  int          k;

  always #5 clk = ~clk;

  present_ti_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pt1(pt1), .pt2(pt2), .pt3(pt3),
    .rk1(rk1), .rk2(rk2), .rk3(rk3),
    .round_idx(round_idx),
    .sboxIn1(sboxIn1), .sboxIn2(sboxIn2), .sboxIn3(sboxIn3),
    .share1(share1), .share2(share2), .share3(share3),
    .ct1(ct1), .ct2(ct2), .ct3(ct3),
    .busy(busy), .done(done)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[60 - 4 * int'(x) +: 4];
  endfunction

  always_comb begin
    rk1 = rka[round_idx];
    rk2 = rkb[round_idx];
    rk3 = rkc[round_idx];
  end

  // Shared S-box with fresh output masks and one cycle of latency
  always @(negedge clk) begin
    m1 <= 4'($urandom);
    m2 <= 4'($urandom);
  end

  always @(posedge clk) begin
    share1 <= m1;
    share2 <= m2;
    share3 <= sb(sboxIn1 ^ sboxIn2 ^ sboxIn3) ^ m1 ^ m2;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_key(input logic [79:0] key);
    logic [79:0] kr;
    logic [63:0] a, b;
    kr = key;
    for (int i = 1; i <= 32; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      rka[i % 32] = a;
      rkb[i % 32] = b;
      rkc[i % 32] = kr[79:16] ^ a ^ b;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sb(kr[79:76]);
      kr[19:15] = kr[19:15] ^ 5'(i);
    end
  endtask

  task automatic set_pt(input logic [63:0] pt);
    pt1 = {$urandom, $urandom};
    pt2 = {$urandom, $urandom};
    pt3 = pt ^ pt1 ^ pt2;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit order, input bit poke, output int n);
    logic [63:0] e;
    logic [3:0]  prev;
    int          c;
    prev = 4'd0;
    n = 0;
    while (!done && n < 2000) begin
      c = n - C0;
      if (order && c >= 0 && c < 16) begin
        e = (pt1 ^ rka[1]) >> (4 * c);
        check($sformatf("nib%0d", c), 64'(sboxIn1), 64'(e[3:0]));
      end
      if (order && c == 1) prev = share1;
      if (order && c == 2) check("wb_lag", 64'(ct1[3:0]), 64'(prev));
      if (order && c == 16)
        check("nib_c16", 64'({sboxIn1, sboxIn2, sboxIn3}), 64'd0);
      if (poke && n == 100) begin
        check("busy_mid", 64'(busy), 64'd1);
        start = 1'b1;
      end
      if (poke && n == 101) start = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ri"}, 64'(round_idx), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ct"}, ct1 | ct2 | ct3, 64'd0);
    check({tag, "_sin"}, 64'({sboxIn1, sboxIn2, sboxIn3}), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pt1 = '0;
    pt2 = '0;
    pt3 = '0;
    set_key(80'h0);
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    set_key(80'h0);
    set_pt(64'h0);
    go();
    wait_done(1'b1, 1'b0, k);
    check("v1_lat", 64'(k + 1), 64'(LAT));
    check("v1_ct", ct1 ^ ct2 ^ ct3, 64'h5579C1387B228445);
    check("v1_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("idle_ri", 64'(round_idx), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    set_key({80{1'b1}});
    set_pt({64{1'b1}});
    go();
    wait_done(1'b0, 1'b1, k);
    check("v2_lat", 64'(k + 1), 64'(LAT));
    check("v2_ct", ct1 ^ ct2 ^ ct3, 64'h3333DCD3213210D2);
    @(negedge clk);

    set_key(80'h0);
    set_pt(64'h0);
    go();
    for (int i = 0; i < 300; i++) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_pt(64'h0);
    go();
    wait_done(1'b0, 1'b0, k);
    check("v3_lat", 64'(k + 1), 64'(LAT));
    check("v3_ct", ct1 ^ ct2 ^ ct3, 64'h5579C1387B228445);

    set_key({80{1'b1}});
    set_pt({64{1'b1}});
    go();
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done", 64'(done), 64'd0);
    check("b2b_ri", 64'(round_idx), 64'd1);
    wait_done(1'b0, 1'b0, k);
    check("b2b_lat", 64'(k + 1), 64'(LAT));
    check("b2b_ct", ct1 ^ ct2 ^ ct3, 64'h3333DCD3213210D2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
